aes_enc_core: RTL

Iterative AES block encryptor, one round per clock, with a valid/ready handshake on input and output. Parametrised over key length (AES-128 or AES-256) and expands round keys on the fly, so no key schedule is stored. It is the computational engine under the AES top level, which supplies 128-bit blocks and collects ciphertext. S-box lookups use the team's combinational `aes_sbox` module (8-bit in, 8-bit out), with 20 instances: 16 for SubBytes and 4 for key expansion.

---
 rtl/aes_sbox.sv | 47 ++++
 rtl/aes_enc_core.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box (FIPS-197 SubBytes table).
// Ports:
//   data_i  8-bit input byte
//   data_o  8-bit substituted byte
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign data_o = SBOX[data_i];

endmodule

// File: rtl/aes_enc_core.sv
// aes_enc_core: iterative AES-128/256 block encryptor, one round per clock, round keys
// expanded on the fly from a sliding key window (nothing of the key schedule is stored).
//
// Parameters:
//   KEY_BITS      128 (Nr=10) or 256 (Nr=14); anything else stops elaboration.
// Ports:
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   in_valid_i    plaintext/key valid          in_ready_o    core idle, will accept
//   plaintext_i   block, bit 0 = MSB of byte 0  key_i         cipher key, same ordering
//   out_valid_o   ciphertext valid             out_ready_i   consumer takes ciphertext
//   ciphertext_o  result (0 when not valid)    busy_o        rounds in progress
// Optional build macro AES_CTR_MODE_EN: CTR mode, adds ctr_load_i / ctr_iv_i; the core
// encrypts an internal counter and returns E(counter) xor the sampled plaintext.
module aes_enc_core #(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [0:127]        plaintext_i,
    input  logic [0:KEY_BITS-1] key_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [0:127]        ciphertext_o,
`ifdef AES_CTR_MODE_EN
    input  logic                ctr_load_i,
    input  logic [0:127]        ctr_iv_i,
`endif
    output logic                busy_o
);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_enc_core: KEY_BITS must be 128 or 256");
    end

    localparam int unsigned NR = (KEY_BITS == 256) ? 14 : 10;
    localparam logic [3:0] LastRound = 4'(NR);

    typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

    fsm_e                fsm_q;
    logic [127:0]        state_q;
    logic [KEY_BITS-1:0] key_q;
    logic [3:0]          round_q;
    logic                in_ready_q;
    logic                busy_q;
    logic                out_valid_q;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- round datapath ----------------
    // Byte i of the block (FIPS order) is state_q[8*(15-i) +: 8]; byte i = row i%4, col i/4.
    logic [7:0]   st_b [16];
    logic [7:0]   sb_b [16];
    logic [7:0]   sr_b [16];
    logic [7:0]   mc_b [16];
    logic [127:0] state_sr;
    logic [127:0] state_mc;
    logic [127:0] round_key;
    logic [127:0] state_next;

    for (genvar g = 0; g < 16; g++) begin : g_sub
        assign st_b[g] = state_q[8*(15-g) +: 8];
        aes_sbox u_sbox (
            .data_i(st_b[g]),
            .data_o(sb_b[g])
        );
        assign state_sr[8*(15-g) +: 8] = sr_b[g];
        assign state_mc[8*(15-g) +: 8] = mc_b[g];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            // ShiftRows: row r rotates left by r columns
            assign sr_b[r + 4*c] = sb_b[r + 4*((c + r) % 4)];
        end
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr_b[4*c];
        assign a1 = sr_b[4*c + 1];
        assign a2 = sr_b[4*c + 2];
        assign a3 = sr_b[4*c + 3];
        assign mc_b[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign mc_b[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign mc_b[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign mc_b[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    assign state_next = ((round_q == LastRound) ? state_sr : state_mc) ^ round_key;

    // ---------------- on-the-fly key expansion ----------------
    logic [31:0]         ks_sub_in;
    logic [31:0]         ks_sub_out;
    logic [KEY_BITS-1:0] key_next;

    for (genvar k = 0; k < 4; k++) begin : g_ks_sbox
        aes_sbox u_sbox (
            .data_i(ks_sub_in[8*k +: 8]),
            .data_o(ks_sub_out[8*k +: 8])
        );
    end

    if (KEY_BITS == 256) begin : g_ks256
        // Window holds {RK_(r-1), RK_r}; round r uses RK_r and builds RK_(r+1).
        logic        gen_rot;
        logic [31:0] t, n0, n1, n2, n3;
        assign round_key = key_q[127:0];
        // Odd current round: the next key starts at a word index divisible by 8.
        assign gen_rot   = round_q[0];
        assign ks_sub_in = gen_rot ? {key_q[23:0], key_q[31:24]} : key_q[31:0];
        assign t  = ks_sub_out ^ (gen_rot ? {rcon((round_q + 4'd1) >> 1), 24'h0} : 32'h0);
        assign n0 = key_q[255:224] ^ t;
        assign n1 = key_q[223:192] ^ n0;
        assign n2 = key_q[191:160] ^ n1;
        assign n3 = key_q[159:128] ^ n2;
        assign key_next = {round_key, n0, n1, n2, n3};
    end else begin : g_ks128
        // Window holds RK_(r-1); round r derives and uses RK_r.
        logic [31:0] t, n0, n1, n2, n3;
        assign ks_sub_in = {key_q[23:0], key_q[31:24]};
        assign t  = ks_sub_out ^ {rcon(round_q), 24'h0};
        assign n0 = key_q[127:96] ^ t;
        assign n1 = key_q[95:64] ^ n0;
        assign n2 = key_q[63:32] ^ n1;
        assign n3 = key_q[31:0] ^ n2;
        assign round_key = {n0, n1, n2, n3};
        assign key_next  = round_key;
    end

    // ---------------- block source / output ----------------
    logic [127:0] block_in;

`ifdef AES_CTR_MODE_EN
    logic [127:0] ctr_q;
    logic [127:0] pt_q;
    assign block_in     = ctr_q;
    assign ciphertext_o = out_valid_q ? (state_q ^ pt_q) : '0;
`else
    assign block_in     = plaintext_i;
    assign ciphertext_o = out_valid_q ? state_q : '0;
`endif

    assign in_ready_o  = in_ready_q;
    assign busy_o      = busy_q;
    assign out_valid_o = out_valid_q;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q       <= StIdle;
            state_q     <= '0;
            key_q       <= '0;
            round_q     <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef AES_CTR_MODE_EN
            ctr_q       <= '0;
            pt_q        <= '0;
`endif
        end else begin
            unique case (fsm_q)
                StIdle: begin
`ifdef AES_CTR_MODE_EN
                    // A counter load wins over a block on the same edge.
                    if (ctr_load_i) begin
                        ctr_q <= ctr_iv_i;
                    end else
`endif
                    if (in_valid_i) begin
                        state_q    <= block_in ^ key_i[0:127];
                        key_q      <= key_i;
                        round_q    <= 4'd1;
                        fsm_q      <= StRound;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef AES_CTR_MODE_EN
                        pt_q          <= plaintext_i;
                        ctr_q[31:0]   <= ctr_q[31:0] + 32'd1;
`endif
                    end
                end
                StRound: begin
                    state_q <= state_next;
                    key_q   <= key_next;
                    if (round_q == LastRound) begin
                        round_q     <= '0;
                        fsm_q       <= StDone;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        fsm_q       <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: fsm_q <= StIdle;
            endcase
        end
    end

endmodule
